// File: rtl/clarvi_soc_button_pkg.sv
// Shared definitions for the ClarVi SoC button poller: poll FSM states,
// the PIO data-register address and the button vector width.
package clarvi_soc_button_pkg;

    localparam int BTN_W = 16;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    typedef enum logic [1:0] {
        WAIT,
        ISSUE,
        CAPTURE,
        UPDATE
    } poll_state_e;

endpackage

// File: rtl/clarvi_soc_button_debounce.sv
// Match counter and accept decision for the button poller. Built only when
// CLARVI_SOC_BUTTON_POLLER_DEBOUNCE_EN is defined; otherwise every poll is accepted.
module clarvi_soc_button_debounce
    import clarvi_soc_button_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             update_i,
    input  logic [BTN_W-1:0] sample_i,
    input  logic [BTN_W-1:0] buttons_i,
    output logic             accept_o
);

`ifdef CLARVI_SOC_BUTTON_POLLER_DEBOUNCE_EN
    localparam logic [3:0] MATCH_TARGET = 4'(DEBOUNCE_SAMPLES);

    logic [3:0]       count_q;
    logic [3:0]       count_d;
    logic [BTN_W-1:0] prev_q;

    // Run length of identical polls, saturating once the target is met.
    always_comb begin
        count_d = count_q;
        if (sample_i == prev_q) begin
            if (count_q < MATCH_TARGET) begin
                count_d = count_q + 4'd1;
            end
        end else begin
            count_d = 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 4'd0;
            prev_q  <= '0;
        end else if (update_i) begin
            count_q <= count_d;
            prev_q  <= sample_i;
        end
    end

    assign accept_o = update_i && (count_d == MATCH_TARGET) && (sample_i != buttons_i);
`else
    logic       unused_inputs;
    logic [3:0] unused_cfg;

    assign unused_inputs = ^{clk, reset, sample_i, buttons_i};
    assign unused_cfg    = 4'(DEBOUNCE_SAMPLES);
    assign accept_o      = update_i;
`endif

endmodule

// File: rtl/clarvi_soc_button_poller.sv
// Polls the button PIO over Avalon-MM, debounces the pressed state and keeps
// sticky press flags with a maskable interrupt. Debounce: CLARVI_SOC_BUTTON_POLLER_DEBOUNCE_EN.
module clarvi_soc_button_poller
    import clarvi_soc_button_pkg::*;
#(
    parameter int POLL_DIV         = 50000,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int ACTIVE_LOW       = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic [31:0]      avm_readdata,
    output logic [BTN_W-1:0] buttons,
    output logic [BTN_W-1:0] edge_capture,
    input  logic             clear_valid,
    input  logic [BTN_W-1:0] clear_mask,
    input  logic [BTN_W-1:0] irq_mask,
    output logic             irq
);

    localparam logic [23:0]      DIV_RELOAD = 24'(POLL_DIV - 1);
    localparam logic [BTN_W-1:0] INV_MASK   = (ACTIVE_LOW != 0) ? {BTN_W{1'b1}} : {BTN_W{1'b0}};

    poll_state_e      state_q;
    logic [23:0]      div_q;
    logic             read_q;
    logic [BTN_W-1:0] sample_q;
    logic [BTN_W-1:0] buttons_q;
    logic [BTN_W-1:0] edge_q;
    logic [BTN_W-1:0] edge_d;
    logic [BTN_W-1:0] set_bits;
    logic [BTN_W-1:0] clr_bits;
    logic             irq_q;
    logic             accept;
    logic             unused_hi;

    assign unused_hi = ^avm_readdata[31:16];

    clarvi_soc_button_debounce #(
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .update_i (state_q == UPDATE),
        .sample_i (sample_q),
        .buttons_i(buttons_q),
        .accept_o (accept)
    );

    // Poll sequencer; the divider is reloaded on every entry to WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT;
            div_q     <= DIV_RELOAD;
            read_q    <= 1'b0;
            sample_q  <= '0;
            buttons_q <= '0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (div_q == 24'd0) begin
                        state_q <= ISSUE;
                        read_q  <= 1'b1;
                    end else begin
                        div_q <= div_q - 24'd1;
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                    read_q  <= 1'b0;
                end
                CAPTURE: begin
                    sample_q <= avm_readdata[BTN_W-1:0] ^ INV_MASK;
                    state_q  <= UPDATE;
                end
                UPDATE: begin
                    if (accept) begin
                        buttons_q <= sample_q;
                    end
                    state_q <= WAIT;
                    div_q   <= DIV_RELOAD;
                end
                default: begin
                    state_q <= WAIT;
                    div_q   <= DIV_RELOAD;
                    read_q  <= 1'b0;
                end
            endcase
        end
    end

    // Presses set flags; a set on the same bit overrides a concurrent clear.
    always_comb begin
        set_bits = '0;
        clr_bits = '0;
        if (accept) begin
            set_bits = sample_q & ~buttons_q;
        end
        if (clear_valid) begin
            clr_bits = clear_mask;
        end
        edge_d = (edge_q & ~clr_bits) | set_bits;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            edge_q <= edge_d;
            irq_q  <= |(edge_q & irq_mask);
        end
    end

    assign avm_address  = PIO_DATA_ADDR;
    assign avm_read     = read_q;
    assign buttons      = buttons_q;
    assign edge_capture = edge_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_clarvi_soc_button_poller.sv
// Self-checking bench for clarvi_soc_button_poller with a latency-1 PIO slave
// and a poll-schedule reference model; honours CLARVI_SOC_BUTTON_POLLER_DEBOUNCE_EN.
module tb_clarvi_soc_button_poller;

    localparam int P   = 4;
    localparam int D   = 3;
    localparam int PER = P + 3;
`ifdef CLARVI_SOC_BUTTON_POLLER_DEBOUNCE_EN
    localparam int FIRST_ACCEPT = P + 3 + (D - 1) * PER;
`else
    localparam int FIRST_ACCEPT = P + 3;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic [15:0] buttons;
    logic [15:0] edge_capture;
    logic        clear_valid;
    logic [15:0] clear_mask;
    logic [15:0] irq_mask;
    logic        irq;
    logic [15:0] in_port;

    int checks = 0;
    int passes = 0;
    bit chkEn  = 0;

    int          mCyc;
    int          mRun;
    logic        mRead;
    logic        mIrq;
    logic [15:0] mButtons;
    logic [15:0] mEdge;
    logic [15:0] mLatched;
    logic [15:0] mSample;
    logic [15:0] mLast;

    clarvi_soc_button_poller #(
        .POLL_DIV        (P),
        .DEBOUNCE_SAMPLES(D),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .avm_address (avm_address),
        .avm_read    (avm_read),
        .avm_readdata(avm_readdata),
        .buttons     (buttons),
        .edge_capture(edge_capture),
        .clear_valid (clear_valid),
        .clear_mask  (clear_mask),
        .irq_mask    (irq_mask),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO slave: registered readdata, latency 1, random upper half.
    initial avm_readdata = 32'h0;
    always @(posedge clk) begin
        if (avm_read) begin
            avm_readdata <= {16'($urandom), in_port};
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mCyc = 0; mRun = 0; mRead = 0; mIrq = 0;
        mButtons = '0; mEdge = '0; mLatched = '0; mSample = '0; mLast = '0;
    endtask

    // Reference: edge n after release; read at n = P + k*PER, slave latch one
    // edge later, capture two later, update three later.
    task automatic modelEdge();
        int          n;
        logic [15:0] setBits;
        logic [15:0] clrBits;
        logic        irqNext;
        bit          accept;
        n       = mCyc + 1;
        setBits = '0;
        clrBits = clear_valid ? clear_mask : 16'h0;
        irqNext = |(mEdge & irq_mask);
        if (n >= P + 3 && (n - P - 3) % PER == 0) begin
            if (mRun > 0 && mSample == mLast) begin
                if (mRun < 100) mRun++;
            end else begin
                mRun = 1;
            end
            mLast = mSample;
`ifdef CLARVI_SOC_BUTTON_POLLER_DEBOUNCE_EN
            accept = (mRun >= D) && (mSample != mButtons);
`else
            accept = 1'b1;
`endif
            if (accept) begin
                setBits  = mSample & ~mButtons;
                mButtons = mSample;
            end
        end
        if (n >= P + 2 && (n - P - 2) % PER == 0) mSample = ~mLatched;
        if (n >= P + 1 && (n - P - 1) % PER == 0) mLatched = in_port;
        mRead = (n >= P) && ((n - P) % PER == 0);
        mEdge = (mEdge & ~clrBits) | setBits;
        mIrq  = irqNext;
        mCyc  = n;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) modelEdge();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] port, input logic [15:0] imask, input int cycles);
        in_port  = port;
        irq_mask = imask;
        repeat (cycles) tick();
    endtask

    task automatic doReset();
        reset = 1'b1;
        modelReset();
        clear_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic strobeClear(input logic [15:0] mask);
        clear_valid = 1'b1;
        clear_mask  = mask;
        tick();
        clear_valid = 1'b0;
        clear_mask  = 16'h0;
    endtask

    // Cycle-by-cycle comparison against the model while out of reset.
    always @(negedge clk) begin
        if (chkEn && !reset) begin
            checkOutput("avm_read", {15'h0, avm_read}, {15'h0, mRead});
            checkOutput("avm_address", {14'h0, avm_address}, 16'h0);
            checkOutput("buttons", buttons, mButtons);
            checkOutput("edge_capture", edge_capture, mEdge);
            checkOutput("irq", {15'h0, irq}, {15'h0, mIrq});
        end
    end

    initial begin
        int pulses;
        int n;
        int hold;
        reset = 1'b1; clear_valid = 1'b0; clear_mask = '0; irq_mask = '0; in_port = 16'hFFFF;
        modelReset();
        #1;
        checkOutput("reset_read", {15'h0, avm_read}, 16'h0);
        checkOutput("reset_buttons", buttons, 16'h0);
        checkOutput("reset_edge", edge_capture, 16'h0);
        checkOutput("reset_irq", {15'h0, irq}, 16'h0);
        doReset();
        chkEn = 1;

        // Idle: one read pulse every PER cycles, nothing pressed.
        in_port = 16'hFFFF; irq_mask = 16'hFFFF;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (avm_read) pulses++;
        end
        checkOutput("idle_pulses", 16'(pulses), 16'd14);
        checkOutput("idle_buttons", buttons, 16'h0);
        checkOutput("idle_irq", {15'h0, irq}, 16'h0);

        // Steady press of bit 0.
        doReset();
        applyStimulus(16'hFFFE, 16'h0001, FIRST_ACCEPT - 1);
        checkOutput("press_before", buttons, 16'h0000);
        applyStimulus(16'hFFFE, 16'h0001, 1);
        checkOutput("press_buttons", buttons, 16'h0001);
        checkOutput("press_edge", edge_capture, 16'h0001);
        checkOutput("press_irq_lag", {15'h0, irq}, 16'h0);
        applyStimulus(16'hFFFE, 16'h0001, 1);
        checkOutput("press_irq", {15'h0, irq}, 16'h0001);

        // Bounce every poll.
        doReset();
        irq_mask = 16'h0;
        for (int i = 0; i < 70; i++) begin
            in_port = ((mCyc / PER) % 2 == 0) ? 16'hFFFE : 16'hFFFF;
            tick();
        end
`ifdef CLARVI_SOC_BUTTON_POLLER_DEBOUNCE_EN
        checkOutput("bounce_buttons", buttons, 16'h0000);
        checkOutput("bounce_edge", edge_capture, 16'h0000);
`else
        checkOutput("bounce_edge", edge_capture, 16'h0001);
`endif

        // Clear colliding with a new press: set wins.
        doReset();
        applyStimulus(16'hFFFE, 16'h0001, FIRST_ACCEPT - 1);
        strobeClear(16'h0001);
        checkOutput("collide_edge", edge_capture, 16'h0001);
        tick();
        checkOutput("collide_irq", {15'h0, irq}, 16'h0001);

        // Reset during CAPTURE.
        n = 0;
        do begin
            tick();
            n++;
        end while (!(mCyc > P && (mCyc - P - 1) % PER == 0) && n < 30);
        checkOutput("find_capture", 16'(n < 30), 16'h1);
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("midreset_read", {15'h0, avm_read}, 16'h0);
        checkOutput("midreset_buttons", buttons, 16'h0);
        checkOutput("midreset_edge", edge_capture, 16'h0);
        checkOutput("midreset_irq", {15'h0, irq}, 16'h0);
        repeat (2) tick();
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!avm_read && n < 50);
        checkOutput("first_read_after_reset", 16'(n), 16'(P));

        // Press then release of bit 3; only the press flags.
        doReset();
        applyStimulus(16'hFFF7, 16'h0008, FIRST_ACCEPT);
        checkOutput("b3_press_buttons", buttons, 16'h0008);
        checkOutput("b3_press_edge", edge_capture, 16'h0008);
        applyStimulus(16'hFFFF, 16'h0008, 3 * PER + 2);
        checkOutput("b3_release_buttons", buttons, 16'h0000);
        checkOutput("b3_release_edge", edge_capture, 16'h0008);
        checkOutput("b3_release_irq", {15'h0, irq}, 16'h0001);
        strobeClear(16'h0008);
        tick();
        checkOutput("b3_cleared_edge", edge_capture, 16'h0000);
        checkOutput("b3_cleared_irq", {15'h0, irq}, 16'h0000);

        // Randomised traffic with one asynchronous reset in the middle.
        doReset();
        hold = 0;
        irq_mask = 16'($urandom);
        for (int i = 0; i < 900; i++) begin
            if (hold == 0) begin
                case ($urandom_range(3))
                    0: in_port = 16'hFFFF;
                    1: in_port = 16'hFFFE;
                    2: in_port = 16'hFFF7;
                    default: in_port = 16'($urandom);
                endcase
                hold = $urandom_range(40, 1);
            end
            hold--;
            clear_valid = ($urandom_range(7) == 0);
            clear_mask  = 16'($urandom);
            if ($urandom_range(31) == 0) irq_mask = 16'($urandom);
            if (i == 450) begin
                doReset();
            end else begin
                tick();
            end
            clear_valid = 1'b0;
        end

        chkEn = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
